io_out_buf: RTL and testbench
=============================

// Module: io_out_buf
// PURPOSE
//  Output-port buffer sitting directly downstream of the fixed-point core's output interface.
//  Captures every core OUT write {addr_out, data_out}; out_en acts as a write strobe.
//  Buffers writes in a FIFO and drains them to external peripherals over a valid/ready handshake.
//  The core has no stall input, so writes arriving while full are dropped and flagged.
// PARAMETERS
//  NUBITS  32  data word width (matches core)
//  NUIOOU   8  number of output addresses; AOW = (NUIOOU>1) ? $clog2(NUIOOU) : 1
//  FDEPTH   4  FIFO address bits; capacity = 2**FDEPTH entries
// PORTS
//  clk       in   1       single clock, all logic rising-edge
//  rst       in   1       asynchronous, active-low reset
//  out_en    in   1       core output strobe (one write per high cycle)
//  addr_out  in   AOW     core output address
//  data_out  in   NUBITS  core output data
//  o_valid   out  1       head entry available
//  o_ready   in   1       consumer accepts head entry
//  o_addr    out  AOW     head entry address
//  o_data    out  NUBITS  head entry data
//  full      out  1       FIFO holds 2**FDEPTH entries
//  ovf       out  1       sticky: a write was dropped
//  ovf_clr   in   1       clears ovf
// BEHAVIOUR
//  Reset (rst=0, async): pointers=0, count=0, o_valid=0, o_addr=0, o_data=0, full=0, ovf=0.
//  Pointers: wr_ptr and rd_ptr are FDEPTH bits wide, wrap modulo 2**FDEPTH; count is FDEPTH+1 bits.
//  Push: out_en && (!full || pop) -> store {addr_out,data_out} at wr_ptr; wr_ptr++.
//  Pop: o_valid && o_ready -> rd_ptr++.
//  Count: push&&!pop -> count+1; pop&&!push -> count-1; both -> unchanged.
//  Full with simultaneous pop: push accepted in the same cycle; nothing dropped, ovf unchanged.
//  Full without pop: out_en high while full && !pop -> write dropped; ovf<=1 next edge.
//  ovf priority: a set in the same cycle as ovf_clr wins (ovf stays 1).
//  Registered outputs: o_valid, o_addr, o_data, full and ovf are all registered.
//  Fall-through timing: first-word fall-through.
//    - Push into empty FIFO at edge N -> o_valid=1 with that entry after edge N.
//    - Total latency is 1 cycle.
//  Empty FIFO: simultaneous push and pop is impossible (o_valid=0), so the push just fills.
//  Head stability: o_addr/o_data are held stable while o_valid && !o_ready.
//  After a pop: the next entry is presented on the following cycle, or o_valid=0 if none.
//  o_ready while !o_valid: ignored.
//  Order: strict FIFO across all addresses; no per-address reordering.
//  Reset mid-stream: all entries are discarded; ovf cleared.
// CONFIGURATION
//  Macro IO_OUT_LEVEL_EN.
//  Defined:
//    - adds output port  level  out  FDEPTH+1  current count, registered.
//    - level is 0 at reset and tracks count after every edge.
//  Undefined:
//    - port is absent, no count register exported.
//    - full still derived internally from pointer/count logic.
// STRUCTURE
//  Shared package io_pkg:
//    - AOW width function
//    - FIFO entry layout constants: ENTRYW = AOW+NUBITS; address field in MSBs.
//  One sub-module io_fifo_mem:
//    - simple dual-port storage, 2**FDEPTH x ENTRYW
//    - synchronous write, asynchronous read at rd_ptr
//    - no reset on storage array
//  Control, pointers, count, flags and output registers live in io_out_buf.
// TESTING
//  1. Single write: out_en=1, addr_out=3, data_out=32'h0000_00A5, o_ready=1
//     -> next cycle o_valid=1, o_addr=3, o_data=A5; popped; then o_valid=0.
//  2. Fill, FDEPTH=4, o_ready=0: 16 writes data 0..15 -> full=1, ovf=0;
//     17th write -> dropped, ovf=1; drain -> 0..15 in order.
//  3. Full + simultaneous push/pop: full, o_ready=1, out_en=1, data 99
//     -> full stays 1, ovf=0, 99 emerges as the last entry.
//  4. Backpressure: o_ready toggles 1010..., continuous writes 1..8 with addresses 0..7
//     -> output sequence exact; head stable whenever o_ready=0.
//  5. ovf_clr coincident with a new drop -> ovf stays 1; later clear with no drop -> ovf=0.
//  6. Assert rst=0 with 5 entries queued
//     -> immediately o_valid=0, full=0, ovf=0; level=0 if IO_OUT_LEVEL_EN is defined.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the core output-port buffer: default sizes and FIFO entry layout.
// Entries are packed {address, data} with the address field in the MSBs.
package io_pkg;

  localparam int NUBITS_DEF = 32;
  localparam int NUIOOU_DEF = 8;
  localparam int FDEPTH_DEF = 4;

  // Address width; a single output address still needs one bit.
  function automatic int aow_f(input int nuioou);
    return (nuioou > 1) ? $clog2(nuioou) : 1;
  endfunction

  function automatic int entryw_f(input int aow, input int nubits);
    return aow + nubits;
  endfunction

  // Bit position where the address field starts inside an entry.
  function automatic int entry_addr_lsb_f(input int nubits);
    return nubits;
  endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// Simple dual-port storage for io_out_buf: synchronous write, asynchronous read.
// The array carries no reset; validity is tracked by the controller.
module io_fifo_mem #(
  parameter int DEPTHW = 4,
  parameter int WIDTH  = 35
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DEPTHW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [DEPTHW-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [2**DEPTHW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/io_out_buf.sv
// Output-port buffer: FWFT FIFO between the core OUT strobe and a valid/ready consumer.
// Optional macro IO_OUT_LEVEL_EN exports the registered fill level on port `level`.
module io_out_buf
  import io_pkg::*;
#(
  parameter int NUBITS = NUBITS_DEF,
  parameter int NUIOOU = NUIOOU_DEF,
  parameter int FDEPTH = FDEPTH_DEF,
  localparam int AOW   = aow_f(NUIOOU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AOW-1:0]    addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [AOW-1:0]    o_addr,
  output logic [NUBITS-1:0] o_data,
  output logic              full,
  output logic              ovf,
  input  logic              ovf_clr
`ifdef IO_OUT_LEVEL_EN
  ,
  output logic [FDEPTH:0]   level
`endif
);

  localparam int ENTRYW   = entryw_f(AOW, NUBITS);
  localparam int ADDR_LSB = entry_addr_lsb_f(NUBITS);

  localparam logic [FDEPTH:0]   CNT_ZERO = (FDEPTH+1)'(0);
  localparam logic [FDEPTH:0]   CNT_ONE  = (FDEPTH+1)'(1);
  localparam logic [FDEPTH:0]   CNT_FULL = (FDEPTH+1)'(2**FDEPTH);
  localparam logic [FDEPTH-1:0] PTR_ONE  = FDEPTH'(1);

  logic [FDEPTH-1:0] wr_ptr_r;
  logic [FDEPTH-1:0] rd_ptr_r;
  logic [FDEPTH-1:0] rd_ptr_nxt_s;
  logic [FDEPTH:0]   count_r;
  logic [FDEPTH:0]   count_left_s;
  logic [FDEPTH:0]   count_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              bypass_s;
  logic [ENTRYW-1:0] wr_entry_s;
  logic [ENTRYW-1:0] rd_entry_s;
  logic [ENTRYW-1:0] head_nxt_s;

  assign wr_entry_s = {addr_out, data_out};

  io_fifo_mem #(
    .DEPTHW (FDEPTH),
    .WIDTH  (ENTRYW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_nxt_s),
    .rdata (rd_entry_s)
  );

  // Handshake decode and next-state of pointers, count and head entry.
  always_comb begin
    pop_s        = o_valid && o_ready;
    push_s       = out_en && (!full || pop_s);
    drop_s       = out_en && full && !pop_s;
    count_left_s = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (pop_s) begin
      count_left_s = count_r - CNT_ONE;
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      count_left_s = count_r;
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s) begin
      count_nxt_s = count_left_s + CNT_ONE;
    end else begin
      count_nxt_s = count_left_s;
    end
    // A write landing in an otherwise empty FIFO is not in storage yet; forward it.
    bypass_s = push_s && (count_left_s == CNT_ZERO);
    if (bypass_s) begin
      head_nxt_s = wr_entry_s;
    end else begin
      head_nxt_s = rd_entry_s;
    end
  end

  // Pointers, count, flags and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      o_valid  <= 1'b0;
      o_addr   <= '0;
      o_data   <= '0;
      full     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full     <= (count_nxt_s == CNT_FULL);
      o_valid  <= (count_nxt_s != CNT_ZERO);
      if (count_nxt_s != CNT_ZERO) begin
        o_addr <= head_nxt_s[ADDR_LSB +: AOW];
        o_data <= head_nxt_s[NUBITS-1:0];
      end
      // A new drop outranks a coincident clear.
      if (drop_s) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef IO_OUT_LEVEL_EN
  assign level = count_r;
`endif

endmodule

// File: tb/tb_io_out_buf.sv
// Self-checking bench for io_out_buf: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_io_out_buf;

  localparam int NUBITS = 32;
  localparam int AOW    = 3;
  localparam int CAP    = 16;

  logic              clk;
  logic              rst;
  logic              out_en;
  logic [AOW-1:0]    addr_out;
  logic [NUBITS-1:0] data_out;
  logic              o_valid;
  logic              o_ready;
  logic [AOW-1:0]    o_addr;
  logic [NUBITS-1:0] o_data;
  logic              full;
  logic              ovf;
  logic              ovf_clr;
`ifdef IO_OUT_LEVEL_EN
  logic [4:0]        level;
`endif

  io_out_buf dut (
    .clk      (clk),
    .rst      (rst),
    .out_en   (out_en),
    .addr_out (addr_out),
    .data_out (data_out),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef IO_OUT_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending writes in arrival order plus the sticky overflow flag.
  logic [AOW-1:0]    q_a [$];
  logic [NUBITS-1:0] q_d [$];
  bit                m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", 64'(o_valid), 64'(q_d.size() > 0));
    chk("full", 64'(full), 64'(q_d.size() == CAP));
    chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef IO_OUT_LEVEL_EN
    chk("level", 64'(level), 64'(q_d.size()));
`endif
    if (q_d.size() > 0) begin
      chk("o_addr", 64'(o_addr), 64'(q_a[0]));
      chk("o_data", 64'(o_data), 64'(q_d[0]));
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic step(input bit en, input int a, input int d, input bit rdy, input bit clr);
    bit pop;
    bit push;
    out_en   = en;
    addr_out = AOW'(a);
    data_out = NUBITS'(d);
    o_ready  = rdy;
    ovf_clr  = clr;
    @(posedge clk);
    pop  = (q_d.size() > 0) && rdy;
    push = en && ((q_d.size() < CAP) || pop);
    if (pop) begin
      void'(q_a.pop_front());
      void'(q_d.pop_front());
    end
    if (push) begin
      q_a.push_back(AOW'(a));
      q_d.push_back(NUBITS'(d));
    end
    if (en && !push) begin
      m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q_d.size() > 0; i++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0);
    end
    chk("drained", 64'(o_valid), 64'(0));
  endtask

  initial begin
    int rp;
    int ep;
    rst = 1'b0; out_en = 1'b0; addr_out = '0; data_out = '0; o_ready = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_addr", 64'(o_addr), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check_all();

    // Single write, then pop.
    step(1'b1, 3, 32'h0000_00A5, 1'b1, 1'b0);
    chk("t1_valid", 64'(o_valid), 64'(1));
    chk("t1_addr", 64'(o_addr), 64'(3));
    chk("t1_data", 64'(o_data), 64'hA5);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t1_empty", 64'(o_valid), 64'(0));

    // Fill to capacity, overflow, drain in order.
    for (int i = 0; i < CAP; i++) step(1'b1, i % 8, i, 1'b0, 1'b0);
    chk("t2_full", 64'(full), 64'(1));
    chk("t2_ovf0", 64'(ovf), 64'(0));
    step(1'b1, 7, 16, 1'b0, 1'b0);
    chk("t2_ovf1", 64'(ovf), 64'(1));
    for (int i = 0; i < CAP; i++) begin
      chk("t2_order", 64'(o_data), 64'(i));
      step(1'b0, 0, 0, 1'b1, 1'b0);
    end
    chk("t2_empty", 64'(o_valid), 64'(0));
    step(1'b0, 0, 0, 1'b0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < CAP; i++) step(1'b1, i % 8, 100 + i, 1'b0, 1'b0);
    step(1'b1, 5, 99, 1'b1, 1'b0);
    chk("t3_full", 64'(full), 64'(1));
    chk("t3_ovf", 64'(ovf), 64'(0));
    for (int i = 0; i < CAP - 1; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t3_last", 64'(o_data), 64'(99));
    drain();

    // Backpressure with o_ready toggling 1010...
    for (int i = 0; i < 8; i++) step(1'b1, i, i + 1, (i % 2) == 0, 1'b0);
    drain();

    // ovf_clr racing a fresh drop, then a clean clear.
    for (int i = 0; i < CAP; i++) step(1'b1, 1, i, 1'b0, 1'b0);
    step(1'b1, 2, 50, 1'b0, 1'b1);
    chk("t5_set_wins", 64'(ovf), 64'(1));
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk("t5_cleared", 64'(ovf), 64'(0));
    step(1'b1, 2, 51, 1'b0, 1'b0);
    drain();

    // Reset with five entries queued and ovf set.
    for (int i = 0; i < CAP; i++) step(1'b1, 4, i, 1'b0, 1'b0);
    step(1'b1, 4, 77, 1'b0, 1'b0);
    for (int i = 0; i < CAP - 5; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t6_pre_count", 64'(q_d.size()), 64'(5));
    o_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 64'(o_valid), 64'(0));
    chk("t6_full", 64'(full), 64'(0));
    chk("t6_ovf", 64'(ovf), 64'(0));
`ifdef IO_OUT_LEVEL_EN
    chk("t6_level", 64'(level), 64'(0));
`endif
    q_a.delete();
    q_d.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all();

    // Randomized traffic with varying producer/consumer rates.
    for (int blk = 0; blk < 8; blk++) begin
      rp = $urandom_range(10, 95);
      ep = $urandom_range(20, 95);
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 99) < ep, $urandom_range(0, 7), $urandom,
             $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 4);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
